// File: rtl/fsmc_master.sv
// FSMC-style multiplexed address/data bus master: one command at a time,
// programmable setup/hold phases, nwait-extended data phase with timeout.
module fsmc_master #(
  parameter int ADDSET   = 2,
  parameter int ADDHLD   = 1,
  parameter int DATAST   = 4,
  parameter int DATAHLD  = 1,
  parameter int WAIT_MAX = 255
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        fsmc_ncs,
  output logic        fsmc_nadv,
  output logic        fsmc_nwe,
  output logic        fsmc_noe,
  output logic [15:0] fsmc_db_o,
  output logic        fsmc_db_oe,
  input  logic [15:0] fsmc_db_i,
  input  logic        fsmc_nwait
);

  typedef enum logic [2:0] {IDLE, ADDR, AHOLD, DATA, DHOLD, TURN} state_t;

  state_t      state_q;
  logic [3:0]  phase_q;
  logic [7:0]  wait_q;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        ncs_q;
  logic        nadv_q;
  logic        nwe_q;
  logic        noe_q;
  logic [15:0] db_o_q;
  logic        db_oe_q;

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign fsmc_ncs   = ncs_q;
  assign fsmc_nadv  = nadv_q;
  assign fsmc_nwe   = nwe_q;
  assign fsmc_noe   = noe_q;
  assign fsmc_db_o  = db_o_q;
  assign fsmc_db_oe = db_oe_q;

  // Every output is set on the edge that enters the state it belongs to,
  // so the bus pins always reflect the current state with no comb path.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      wait_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      ncs_q       <= 1'b1;
      nadv_q      <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      db_o_q      <= '0;
      db_oe_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            wr_q        <= cmd_wr;
            wdata_q     <= cmd_wdata;
            state_q     <= ADDR;
            phase_q     <= 4'(ADDSET - 1);
            wait_q      <= '0;
            cmd_ready_q <= 1'b0;
            ncs_q       <= 1'b0;
            nadv_q      <= 1'b0;
            db_oe_q     <= 1'b1;
            db_o_q      <= cmd_addr;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ADDR: begin
          if (phase_q == 4'd0) begin
            state_q <= AHOLD;
            phase_q <= 4'(ADDHLD - 1);
            wait_q  <= '0;
            nadv_q  <= 1'b1;
          end else begin
            phase_q <= phase_q - 4'd1;
          end
        end
        AHOLD: begin
          if (phase_q == 4'd0) begin
            state_q <= DATA;
            phase_q <= 4'(DATAST - 1);
            wait_q  <= '0;
            if (wr_q) begin
              nwe_q  <= 1'b0;
              db_o_q <= wdata_q;
            end else begin
              noe_q   <= 1'b0;
              db_oe_q <= 1'b0;
            end
          end else begin
            phase_q <= phase_q - 4'd1;
          end
        end
        DATA: begin
          // wait_q counts extension cycles already spent beyond DATAST.
          if (phase_q != 4'd0) begin
            phase_q <= phase_q - 4'd1;
          end else if (fsmc_nwait || (wait_q == 8'(WAIT_MAX))) begin
            state_q     <= DHOLD;
            phase_q     <= 4'(DATAHLD - 1);
            wait_q      <= '0;
            nwe_q       <= 1'b1;
            noe_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~fsmc_nwait;
            if (!fsmc_nwait) begin
              rsp_rdata_q <= '0;
            end else if (!wr_q) begin
              rsp_rdata_q <= fsmc_db_i;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DHOLD: begin
          if (phase_q == 4'd0) begin
            state_q <= TURN;
            phase_q <= '0;
            wait_q  <= '0;
            ncs_q   <= 1'b1;
            db_oe_q <= 1'b0;
          end else begin
            phase_q <= phase_q - 4'd1;
          end
        end
        TURN: begin
          state_q     <= IDLE;
          phase_q     <= '0;
          wait_q      <= '0;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          phase_q     <= '0;
          wait_q      <= '0;
          cmd_ready_q <= 1'b0;
          ncs_q       <= 1'b1;
          nadv_q      <= 1'b1;
          nwe_q       <= 1'b1;
          noe_q       <= 1'b1;
          db_oe_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsmc_master.sv
// Scoreboard bench for fsmc_master: per-cycle bus-phase checks plus
// queued response checks for writes, reads, nwait extension, timeout and reset.
module tb_fsmc_master;

  localparam int DATAST   = 4;
  localparam int WAIT_MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        fsmc_ncs;
  logic        fsmc_nadv;
  logic        fsmc_nwe;
  logic        fsmc_noe;
  logic [15:0] fsmc_db_o;
  logic        fsmc_db_oe;
  logic [15:0] fsmc_db_i;
  logic        fsmc_nwait;

  fsmc_master #(
    .ADDSET(2), .ADDHLD(1), .DATAST(DATAST), .DATAHLD(1), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .sys_clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fsmc_ncs(fsmc_ncs), .fsmc_nadv(fsmc_nadv), .fsmc_nwe(fsmc_nwe),
    .fsmc_noe(fsmc_noe), .fsmc_db_o(fsmc_db_o), .fsmc_db_oe(fsmc_db_oe),
    .fsmc_db_i(fsmc_db_i), .fsmc_nwait(fsmc_nwait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          base;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc_g = 0;
  logic [15:0] rdata_m = 16'h0000;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pops the expected completion on every rsp_valid.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, mon_e.rdata});
        check("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
        if (mon_e.cyc >= 0) check("rsp_cycle", cyc_g - mon_e.base, mon_e.cyc);
      end
    end
  end

  // Expected {ncs,nadv,nwe,noe,db_oe,rsp_valid} for cycle k after acceptance.
  function automatic logic [5:0] exp_sig(input int k, input int dend, input logic wr);
    if (k <= 2) return 6'b001110;
    if (k == 3) return 6'b011110;
    if (k <= dend) return wr ? 6'b010110 : 6'b011000;
    if (k == dend + 1) return wr ? 6'b011111 : 6'b011101;
    return 6'b111100;
  endfunction

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic do_txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input int extra, input logic stuck, input logic hold);
    int   k;
    int   dend;
    int   rsp_k;
    logic done;
    check("cmd_ready_at_issue", {31'h0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = wr ? d : 16'($urandom);
    dend = 3 + DATAST + extra;
    if (stuck) rdata_m = 16'h0000;
    else if (!wr) rdata_m = d;
    sb_q.push_back('{rdata_m, stuck, cyc_g, stuck ? -1 : dend + 1});
    $display("txn %s addr=%h data=%h extra=%0d stuck=%0d", wr ? "WR" : "RD", a, d, extra, stuck);
    k = 0;
    rsp_k = -1;
    done = 1'b0;
    while (!done && k < 80) begin
      @(negedge clk);
      k++;
      if (!hold) cmd_valid = 1'b0;
      fsmc_nwait = !((stuck && k < 3) || (k >= 3 + DATAST && (stuck || k < 3 + DATAST + extra)));
      fsmc_db_i  = (k >= 4 && (stuck || k <= dend)) ? d : ~d;
      check("nwe_noe_excl", {31'h0, (fsmc_nwe | fsmc_noe)}, 32'd1);
      if (!stuck) begin
        check("strobes", {26'h0, fsmc_ncs, fsmc_nadv, fsmc_nwe, fsmc_noe, fsmc_db_oe, rsp_valid},
              {26'h0, exp_sig(k, dend, wr)});
        if (k <= 3) check("db_o_addr", {16'h0, fsmc_db_o}, {16'h0, a});
        if (wr && k >= 4 && k <= dend + 1) check("db_o_wdata", {16'h0, fsmc_db_o}, {16'h0, d});
      end else if (rsp_valid) begin
        rsp_k = k;
      end
      if (cmd_ready) done = 1'b1;
    end
    fsmc_nwait = 1'b1;
    if (!done) check("txn_timeout", 32'd0, 32'd1);
    else if (!stuck) check("ready_cycle", k, dend + 3);
    else check("ready_after_err", k, rsp_k + 2);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_wr     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    fsmc_db_i  = '0;
    fsmc_nwait = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_strobes", {27'h0, fsmc_ncs, fsmc_nadv, fsmc_nwe, fsmc_noe, fsmc_db_oe}, {27'h0, 5'b11110});
    check("rst_db_o", {16'h0, fsmc_db_o}, 32'h0);
    check("rst_ready", {31'h0, cmd_ready}, 32'd0);
    check("rst_rsp", {14'h0, rsp_valid, rsp_err, rsp_rdata}, 32'h0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {31'h0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_edge", {31'h0, cmd_ready}, 32'd1);

    do_txn(1'b1, 16'h1234, 16'hBEEF, 0, 1'b0, 1'b0);
    do_txn(1'b0, 16'h0040, 16'h5A5A, 0, 1'b0, 1'b0);
    do_txn(1'b0, 16'h0100, 16'hC3C3, 3, 1'b0, 1'b0);
    do_txn(1'b1, 16'hFFFF, 16'h0001, 2, 1'b0, 1'b0);
    do_txn(1'b0, 16'h0200, 16'h7777, 0, 1'b1, 1'b0);
    do_txn(1'b0, 16'h0300, 16'hA5A5, 0, 1'b0, 1'b0);
    do_txn(1'b1, 16'h3000, 16'h1111, 0, 1'b0, 1'b1);
    do_txn(1'b0, 16'h3001, 16'h2222, 0, 1'b0, 1'b0);

    // Reset in the middle of a write data phase.
    $display("txn WR addr=4000 data=9999 reset-in-DATA");
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h4000; cmd_wdata = 16'h9999;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_nwe", {31'h0, fsmc_nwe}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_strobes", {27'h0, fsmc_ncs, fsmc_nadv, fsmc_nwe, fsmc_noe, fsmc_db_oe}, {27'h0, 5'b11110});
    check("arst_ready", {31'h0, cmd_ready}, 32'd0);
    check("arst_rsp", {14'h0, rsp_valid, rsp_err, rsp_rdata}, 32'h0);
    rdata_m = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ready_before_edge", {31'h0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("rel_ready_after_edge", {31'h0, cmd_ready}, 32'd1);

    do_txn(1'b0, 16'h5000, 16'h0F0F, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsmc_master.md
FSMC_MASTER -- requirements
Module: fsmc_master

Interface
REQ-001 Parameter ADDSET, default 2, address-phase length in sys_clk cycles, legal 1..15.
REQ-002 Parameter ADDHLD, default 1, address-hold length in cycles, legal 1..15.
REQ-003 Parameter DATAST, default 4, minimum data-phase length in cycles, legal 1..15.
REQ-004 Parameter DATAHLD, default 1, data-hold length in cycles, legal 1..15.
REQ-005 Parameter WAIT_MAX, default 255, maximum nwait extension cycles before abort, legal 1..255.
REQ-006 sys_clk  input  1  single clock for all logic; one clock, no other clock domains.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 cmd_valid  input  1  command request.
REQ-009 cmd_ready  output  1  high when the block can accept a command.
REQ-010 cmd_wr  input  1  1 = write, 0 = read.
REQ-011 cmd_addr  input  16  bus address, driven on the multiplexed bus in the address phase.
REQ-012 cmd_wdata  input  16  write data.
REQ-013 rsp_valid  output  1  one-cycle completion pulse (read and write).
REQ-014 rsp_rdata  output  16  read data, valid with rsp_valid.
REQ-015 rsp_err  output  1  nwait timeout flag, valid with rsp_valid.
REQ-016 fsmc_ncs  output  1  chip select, active-low.
REQ-017 fsmc_nadv  output  1  address valid, active-low.
REQ-018 fsmc_nwe  output  1  write strobe, active-low.
REQ-019 fsmc_noe  output  1  read strobe, active-low.
REQ-020 fsmc_db_o / fsmc_db_oe / fsmc_db_i  output/output/input  16/1/16  split tri-state multiplexed AD bus; the top level builds the inout.
REQ-021 fsmc_nwait  input  1  target wait request, active-low, synchronous to sys_clk.

Function
REQ-022 All fsmc_* outputs, cmd_ready, rsp_* SHALL be registered; no combinational path from inputs to fsmc_* outputs.
REQ-023 States SHALL be IDLE, ADDR, AHOLD, DATA, DHOLD, TURN.
REQ-024 IDLE: cmd_ready=1, ncs/nadv/nwe/noe=1, db_oe=0; cmd_valid&cmd_ready captures cmd_wr/addr/wdata and moves to ADDR next cycle; cmd_ready drops in the same cycle the FSM leaves IDLE.
REQ-025 ADDR, ADDSET cycles: ncs=0, nadv=0, db_oe=1, db_o=addr.
REQ-026 AHOLD, ADDHLD cycles: ncs=0, nadv=1, db_oe=1, db_o=addr.
REQ-027 DATA, write: ncs=0, nwe=0, db_oe=1, db_o=wdata; read: ncs=0, noe=0, db_oe=0.
REQ-028 DATA SHALL last DATAST cycles minimum; if fsmc_nwait=0 is sampled on the last minimum cycle, DATA extends until nwait=1 is sampled, and the data phase ends on the cycle nwait=1 is sampled.
REQ-029 Read data SHALL be sampled from fsmc_db_i at the sys_clk edge ending the last DATA cycle.
REQ-030 If the extension reaches WAIT_MAX cycles with nwait still 0, DATA SHALL end with rsp_err=1 and rsp_rdata=0x0000.
REQ-031 DHOLD, DATAHLD cycles: ncs=0, nwe=noe=1; write keeps db_oe=1 and db_o=wdata; read keeps db_oe=0.
REQ-032 rsp_valid SHALL pulse for exactly one cycle, the first DHOLD cycle; rsp_rdata and rsp_err are held until the next rsp_valid; rsp_rdata is unchanged on writes.
REQ-033 TURN, 1 cycle: all strobes high, db_oe=0 (bus turnaround); then IDLE.
REQ-034 Defaults, no wait, acceptance at edge E0: cycles 1-2 ADDR, 3 AHOLD, 4-7 DATA, 8 DHOLD (rsp_valid), 9 TURN, 10 IDLE with cmd_ready=1.
REQ-035 cmd_valid outside IDLE SHALL be ignored; commands are never queued.
REQ-036 fsmc_nwait SHALL be ignored outside DATA.
REQ-037 nwe and noe SHALL never be low simultaneously; nadv SHALL be low only in ADDR.
REQ-038 The 4-bit phase counter and 8-bit wait counter SHALL reload on each state entry.

Reset
REQ-039 rst_n=0 SHALL asynchronously force: state IDLE, ncs/nadv/nwe/noe=1, db_oe=0, db_o=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0x0000.
REQ-040 cmd_ready SHALL rise on the first sys_clk edge after rst_n deasserts.
REQ-041 Reset during any state SHALL abort the transaction with no rsp_valid.

Verification
REQ-042 Write addr 0x1234 data 0xBEEF, defaults, nwait=1 -> db_o=0x1234 with nadv=0 for cycles 1-2, db_o=0xBEEF with nwe=0 for cycles 4-7, rsp_valid on cycle 8, cmd_ready on cycle 10.
REQ-043 Read addr 0x0040, target drives 0x5A5A -> noe=0 for cycles 4-7, db_oe=0 for cycles 4-9, rsp_valid on cycle 8 with rsp_rdata=0x5A5A and rsp_err=0.
REQ-044 Read, nwait=0 for 3 extra cycles -> DATA lasts 7 cycles, rsp_valid on cycle 11, correct data.
REQ-045 Read, nwait stuck at 0, WAIT_MAX=8 -> rsp_valid with rsp_err=1 and rsp_rdata=0x0000, then TURN and IDLE.
REQ-046 cmd_valid held high across back-to-back commands -> second command accepted only on cycle 10, no overlap of ncs windows.
REQ-047 rst_n pulsed low during DATA of a write -> nwe/ncs high and db_oe=0 immediately (asynchronously), no rsp_valid, cmd_ready=1 one edge after release.
